// File: rtl/pool_pkg.sv
// Shared types and parameter helpers for the streaming pooling layer.
// Accumulator width and average shift are derived from DATA_W and POOL.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    function automatic int acc_width(input int data_w, input int pool);
        return data_w + 2 * $clog2(pool);
    endfunction

    function automatic int avg_shift(input int pool);
        return 2 * $clog2(pool);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(
        input int img_w,
        input int img_h,
        input int pool
    );
        return is_pow2(pool) && (pool >= 2) &&
               (img_w >= pool) && (img_h >= pool) &&
               (img_w % pool == 0) && (img_h % pool == 0);
    endfunction

endpackage

// File: rtl/pool_accum_buf.sv
// Line buffer of per-window accumulators, one entry per window column.
// Same-index read and write each cycle; contents need no reset.
module pool_accum_buf
    import pool_pkg::*;
#(
    parameter int ACC_W = 36,
    parameter int DEPTH = 2,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_data,
    output logic [ACC_W-1:0] rd_data
);

    logic [ACC_W-1:0] mem [DEPTH];

    assign rd_data = mem[idx];

    // Store the updated partial window result
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/stream_pool_layer.sv
// Streaming max/average pooling over non-overlapping POOLxPOOL windows.
// Counters, frame mode latch, output register and handshake live here.
module stream_pool_layer
    import pool_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int POOL   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);

    localparam int ACC_W = acc_width(DATA_W, POOL);
    localparam int SHIFT = avg_shift(POOL);
    localparam int PW    = $clog2(POOL);
    localparam int NWIN  = IMG_W / POOL;
    localparam int IDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    generate
        if (!params_ok(IMG_W, IMG_H, POOL)) begin : g_bad_params
            $error("stream_pool_layer: illegal IMG_W/IMG_H/POOL");
        end
    endgenerate

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    pool_mode_e       mode_q;
    pool_mode_e       frame_mode;
    logic             accept;
    logic             first_px;
    logic             last_px;
    logic             frame_first;
    logic             frame_last;
    logic [IDX_W-1:0] win_idx;
    logic [ACC_W-1:0] entry;
    logic [ACC_W-1:0] px_ext;
    logic [ACC_W-1:0] combined;
    logic [DATA_W-1:0] result;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign first_px = (col[PW-1:0] == '0) &&
                      (row[PW-1:0] == '0);
    assign last_px  = (col[PW-1:0] == '1) &&
                      (row[PW-1:0] == '1);

    assign frame_first = (col == '0) && (row == '0);
    assign frame_last  = (col == CW'(IMG_W - 1)) &&
                         (row == RW'(IMG_H - 1));

    // Pixel (0,0) uses the live pin; the rest of the frame the latch
    assign frame_mode = frame_first ? pool_mode_e'(mode) : mode_q;

    assign win_idx = IDX_W'(col >> PW);
    assign px_ext  = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};

    pool_accum_buf #(
        .ACC_W (ACC_W),
        .DEPTH (NWIN)
    ) u_buf (
        .clk     (clk),
        .idx     (win_idx),
        .wr_en   (accept),
        .wr_data (combined),
        .rd_data (entry)
    );

    // Merge the incoming pixel into its window's accumulator
    always_comb begin
        combined = px_ext;
        if (!first_px) begin
            if (frame_mode == POOL_AVG) begin
                combined = entry + px_ext;
            end else if ($signed(entry) > $signed(px_ext)) begin
                combined = entry;
            end
        end
    end

    // Final window value: floor-divide the sum, or pass the max through
    always_comb begin
        result = combined[DATA_W-1:0];
        if (frame_mode == POOL_AVG) begin
            result = DATA_W'($signed(combined) >>> SHIFT);
        end
    end

    // Raster position of the next accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                if (row == RW'(IMG_H - 1)) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Capture the pooling mode once per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= POOL_MAX;
        end else if (accept && frame_first) begin
            mode_q <= pool_mode_e'(mode);
        end
    end

    // Output register: a new result wins over draining the old one
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else if (accept && last_px) begin
            out_valid  <= 1'b1;
            out_data   <= result;
            frame_done <= frame_last;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_pool_layer.sv
// Scoreboard bench for stream_pool_layer on a 4x4 map, POOL=2.
// Directed frames first, then randomized data, modes and backpressure.
module tb_stream_pool_layer;

    localparam int DW   = 32;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int P    = 2;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          frame_done;

    always #5 clk = ~clk;

    stream_pool_layer #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H),
        .POOL   (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    int   m_cnt = 0;
    logic m_mode = 1'b0;
    int   m_pix[NPIX];

    logic [DW-1:0] fr_px[NPIX];
    logic          fr_md[NPIX];

    bit rand_ready = 0;
    bit arm_stall  = 0;
    int stall_cnt  = 0;
    int gap_max    = 0;

    logic          held;
    logic [DW-1:0] held_data;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: keep the frame's pixels, pool each window once complete
    task automatic model_accept(input logic [DW-1:0] d,
                                input logic m,
                                output bit closed);
        int r;
        int c;
        int v;
        int mx;
        longint s;
        longint q;
        exp_t e;
        if (m_cnt == 0) m_mode = m;
        m_pix[m_cnt] = d;
        r = m_cnt / W;
        c = m_cnt % W;
        closed = (r % P == P - 1) && (c % P == P - 1);
        if (closed) begin
            s  = 0;
            mx = m_pix[(r - P + 1) * W + (c - P + 1)];
            for (int dr = 0; dr < P; dr++) begin
                for (int dc = 0; dc < P; dc++) begin
                    v = m_pix[(r - P + 1 + dr) * W + (c - P + 1 + dc)];
                    s += v;
                    if (v > mx) mx = v;
                end
            end
            if (m_mode) begin
                q = s / (P * P);
                if (s < 0 && (s % (P * P)) != 0) q = q - 1;
                e.data = DW'(q);
            end else begin
                e.data = mx;
            end
            e.last = (m_cnt == NPIX - 1);
            sb.push_back(e);
        end
        m_cnt = (m_cnt + 1) % NPIX;
    endtask

    // Downstream ready: always, random, or a one-shot 10-cycle stall
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (arm_stall && out_valid) begin
                arm_stall = 0;
                stall_cnt = 10;
            end
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: handshake checks against the scoreboard head
    initial begin
        exp_t e;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                check("in_ready", 64'(in_ready),
                      64'(!out_valid || out_ready));
                if (held) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_data", 64'(out_data), 64'(held_data));
                end
                if (!out_valid) begin
                    check("frame_done_idle", 64'(frame_done), 64'd0);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_out: got %0h expected none",
                                 out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 64'(out_data), 64'(e.data));
                        check("frame_done", 64'(frame_done), 64'(e.last));
                    end
                end
                held = out_valid && !out_ready;
                held_data = out_data;
            end
        end
    end

    task automatic send_pixel(input logic [DW-1:0] d, input logic m);
        int budget;
        int g;
        bit closed;
        budget = 0;
        g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            @(negedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            budget++;
            if (budget > 200) begin
                $display("FAIL in_ready_timeout: got 0 expected 1");
                $fatal(1, "input stalled");
            end
        end
        model_accept(d, m, closed);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        if (closed) check("latency_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic send_frame();
        for (int i = 0; i < NPIX; i++) send_pixel(fr_px[i], fr_md[i]);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        m_cnt = 0;
        m_mode = 1'b0;
        sb.delete();
    endtask

    task automatic load_pattern(input logic m);
        for (int i = 0; i < NPIX; i++) begin
            if ((i / W) % 2 == 0) fr_px[i] = DW'((i % W) + 1);
            else fr_px[i] = DW'(W - (i % W));
            fr_md[i] = m;
        end
    endtask

    task automatic load_random(input logic m);
        for (int i = 0; i < NPIX; i++) begin
            fr_px[i] = $urandom;
            fr_md[i] = m;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        mode = 1'b0;
        @(negedge clk);
        #1;
        do_reset();

        load_pattern(1'b0);
        send_frame();
        drain();

        load_pattern(1'b1);
        send_frame();
        drain();

        for (int m = 0; m < 2; m++) begin
            load_random(1'(m));
            fr_px[0]     = -5;
            fr_px[1]     = -3;
            fr_px[W]     = -8;
            fr_px[W + 1] = -1;
            send_frame();
            drain();
        end

        arm_stall = 1;
        load_pattern(1'b0);
        send_frame();
        drain();

        load_random(1'b0);
        for (int i = 6; i < NPIX; i++) fr_md[i] = 1'b1;
        send_frame();
        load_random(1'b1);
        send_frame();
        drain();

        load_random(1'b1);
        for (int i = 0; i < 7; i++) send_pixel(fr_px[i], fr_md[i]);
        drain();
        do_reset();
        load_random(1'b0);
        send_frame();
        drain();

        rand_ready = 1;
        gap_max = 2;
        for (int f = 0; f < 20; f++) begin
            load_random(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = $urandom_range(1, NPIX - 1); i < NPIX; i++)
                    fr_md[i] = ~fr_md[0];
            end
            send_frame();
        end
        rand_ready = 0;
        gap_max = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
